dac_frame_scheduler: RTL and testbench

Round-robin scheduler that shares one DAC serial port among NUM_REQ command requesters. Each requester is a waveform engine or a host register path. After reset it sends one control-register configuration frame to the DAC. It then grants requesters in turn and serializes each 24-bit command MSB-first on a divided SPI clock. After each data frame it pulses LDAC so the new code reaches the output. It sits between the per-channel waveform generators and the DAC pins, and owns the DAC clr, sync, sclk, din and ldac pins.

---
 rtl/dac_frame_scheduler.sv | 140 ++++++++++++++
 tb/tb_dac_frame_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_scheduler.sv
// dac_frame_scheduler: round-robin DAC serial port sharing; `define FRAME_CNT_EN adds frame_count
module dac_frame_scheduler #(
  parameter int          NUM_REQ   = 4,
  parameter logic [23:0] CTRL_WORD = 24'h200012,
  parameter int          GAP_CYC   = 6,
  parameter int          LDAC_CYC  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [24*NUM_REQ-1:0]   cmd,
  input  logic                    clear_request,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    busy,
  output logic                    init_done,
  output logic                    dac_clr_n,
  output logic                    dac_sync_n,
  output logic                    dac_sclk,
  output logic                    dac_din,
  output logic                    dac_ldac_n
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0]             frame_count
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int MX = (GAP_CYC > 48) ? ((GAP_CYC > LDAC_CYC) ? GAP_CYC : LDAC_CYC)
                                     : ((LDAC_CYC > 48) ? LDAC_CYC : 48);
  localparam int CW = $clog2(MX);
  typedef enum logic [2:0] {INIT, SHIFT, GAP, LDAC, IDLE} state_t;
  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [23:0]       sreg, sreg_nxt;
  logic [PW-1:0]     rr_ptr, rr_nxt, gnt, gnt_nxt, pick, j;
  logic              hit;
  logic [NUM_REQ-1:0] ack_nxt;
  logic              busy_nxt, init_done_nxt, sync_nxt, sclk_nxt, din_nxt, ldac_nxt;

  // Scan from the far end so the requester closest to rr_ptr wins.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    j    = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      j = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[j]) begin
        hit  = 1'b1;
        pick = j;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    sreg_nxt  = sreg;
    rr_nxt    = rr_ptr;
    gnt_nxt   = gnt;
    case (state)
      INIT: begin
        state_nxt = SHIFT;
        cnt_nxt   = '0;
        sreg_nxt  = CTRL_WORD;
      end
      IDLE: if (hit && !clear_request) begin
        state_nxt = SHIFT;
        cnt_nxt   = '0;
        sreg_nxt  = cmd[24*pick +: 24];
        gnt_nxt   = pick;
        rr_nxt    = PW'((int'(pick) + 1) % NUM_REQ);
      end
      SHIFT: begin
        if (cnt[0]) sreg_nxt = {sreg[22:0], 1'b0};
        if (cnt == CW'(47)) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end
      GAP: if (cnt == CW'(GAP_CYC-1)) begin
        state_nxt = init_done ? LDAC : IDLE;
        cnt_nxt   = '0;
      end
      LDAC: if (cnt == CW'(LDAC_CYC-1)) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Pins are decoded from the next state so the registered outputs line up with state.
  always_comb begin
    busy_nxt      = state_nxt != IDLE;
    init_done_nxt = init_done | (state_nxt == IDLE);
    sync_nxt      = state_nxt != SHIFT;
    sclk_nxt      = state_nxt != SHIFT || !cnt_nxt[0];
    din_nxt       = state_nxt == SHIFT && sreg_nxt[23];
    ldac_nxt      = state_nxt != LDAC;
    ack_nxt       = (state_nxt == LDAC && cnt_nxt == CW'(LDAC_CYC-1)) ? NUM_REQ'(1) << gnt_nxt : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT;
      cnt        <= '0;
      sreg       <= CTRL_WORD;
      rr_ptr     <= '0;
      gnt        <= '0;
      ack        <= '0;
      busy       <= 1'b1;
      init_done  <= 1'b0;
      dac_clr_n  <= 1'b1;
      dac_sync_n <= 1'b1;
      dac_sclk   <= 1'b1;
      dac_din    <= 1'b0;
      dac_ldac_n <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sreg       <= sreg_nxt;
      rr_ptr     <= rr_nxt;
      gnt        <= gnt_nxt;
      ack        <= ack_nxt;
      busy       <= busy_nxt;
      init_done  <= init_done_nxt;
      dac_clr_n  <= ~clear_request;
      dac_sync_n <= sync_nxt;
      dac_sclk   <= sclk_nxt;
      dac_din    <= din_nxt;
      dac_ldac_n <= ldac_nxt;
    end
  end

`ifdef FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_count <= '0;
    else if (|ack) frame_count <= frame_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb_dac_frame_scheduler: directed checks of init frame, data frames, round robin, clear and reset abort
module tb_dac_frame_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [95:0] cmd;
  logic        clear_request;
  logic [3:0]  ack;
  logic        busy, init_done, dac_clr_n, dac_sync_n, dac_sclk, dac_din, dac_ldac_n;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_count;
`endif
  int n_tests = 0;
  int n_fail  = 0;
  int ldac_lows = 0;
  int ack_pulses = 0;

  dac_frame_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .clear_request(clear_request),
    .ack(ack), .busy(busy), .init_done(init_done), .dac_clr_n(dac_clr_n),
    .dac_sync_n(dac_sync_n), .dac_sclk(dac_sclk), .dac_din(dac_din), .dac_ldac_n(dac_ldac_n)
`ifdef FRAME_CNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ldac_lows  += int'(!dac_ldac_n);
    ack_pulses += int'(|ack);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sync();
    for (int i = 0; i < 200 && dac_sync_n; i++) @(negedge clk);
    chk("sync_start", {31'd0, dac_sync_n}, 32'd0);
  endtask

  // Collects 24 bits on the sclk-low half of each bit; ok covers sync, sclk phase and din hold.
  task automatic capture(output logic [23:0] w, output logic ok);
    logic d;
    w  = '0;
    ok = 1'b1;
    d  = 1'b0;
    wait_sync();
    for (int i = 0; i < 48; i++) begin
      if (i > 0) @(negedge clk);
      ok &= !dac_sync_n && (dac_sclk === !i[0]);
      if (!i[0]) d = dac_din;
      else begin
        ok &= (dac_din === d);
        w = {w[22:0], dac_din};
      end
    end
  endtask

  task automatic run_frame(input logic [23:0] exp_w, input logic [3:0] exp_ack, input string tag);
    logic [23:0] w;
    logic        ok;
    capture(w, ok);
    chk({tag, "_word"}, {8'd0, w}, {8'd0, exp_w});
    chk({tag, "_shape"}, {31'd0, ok}, 32'd1);
    repeat (7) @(negedge clk);
    chk({tag, "_ldac_first"}, {31'd0, dac_ldac_n}, 32'd0);
    chk({tag, "_no_early_ack"}, {28'd0, ack}, 32'd0);
    @(negedge clk);
    chk({tag, "_ack"}, {28'd0, ack}, {28'd0, exp_ack});
    chk({tag, "_ldac_last"}, {31'd0, dac_ldac_n}, 32'd0);
  endtask

  initial begin
    logic [23:0] w;
    logic        ok;
    logic [23:0] rr_words [4];
    int          lows;
    int          acks_before;
    rr_words[0] = 24'h0A5A5A;
    rr_words[1] = 24'h3C3C3C;
    rr_words[2] = 24'h123456;
    rr_words[3] = 24'hFEDCBA;
    rst = 1'b0;
    req = '0;
    cmd = '0;
    clear_request = 1'b0;
    @(negedge clk);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_clr_n", {31'd0, dac_clr_n}, 32'd1);
    chk("rst_sync_n", {31'd0, dac_sync_n}, 32'd1);
    chk("rst_sclk", {31'd0, dac_sclk}, 32'd1);
    chk("rst_din", {31'd0, dac_din}, 32'd0);
    chk("rst_ldac_n", {31'd0, dac_ldac_n}, 32'd1);
    rst = 1'b1;
    capture(w, ok);
    chk("init_word", {8'd0, w}, 32'h200012);
    chk("init_shape", {31'd0, ok}, 32'd1);
    @(negedge clk);
    chk("init_gap_sync", {31'd0, dac_sync_n}, 32'd1);
    chk("init_gap_done", {31'd0, init_done}, 32'd0);
    repeat (5) @(negedge clk);
    chk("init_gap_last_done", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    chk("init_done", {31'd0, init_done}, 32'd1);
    chk("init_idle_busy", {31'd0, busy}, 32'd0);
    chk("init_no_ldac", ldac_lows, 32'd0);

    cmd[48 +: 24] = 24'h01ABCD;
    req = 4'b0100;
    run_frame(24'h01ABCD, 4'b0100, "req2");
    req = 4'b0000;
    @(negedge clk);
    chk("req2_ack_once", {28'd0, ack}, 32'd0);
    chk("req2_ldac_release", {31'd0, dac_ldac_n}, 32'd1);
    chk("req2_idle", {31'd0, busy}, 32'd0);
    chk("req2_ldac_cycles", ldac_lows, 32'd2);

    cmd[72 +: 24] = 24'hF00F5A;
    req = 4'b1000;
    run_frame(24'hF00F5A, 4'b1000, "req3");
    req = 4'b0000;
    @(negedge clk);

    for (int k = 0; k < 4; k++) cmd[24*k +: 24] = rr_words[k];
    req = 4'b1111;
    for (int k = 0; k < 5; k++) run_frame(rr_words[k % 4], 4'b0001 << (k % 4), "rr");
    req = 4'b0000;
    @(negedge clk);

    req = 4'b0001;
    wait_sync();
    repeat (10) @(negedge clk);
    clear_request = 1'b1;
    cmd[24 +: 24] = 24'h0C0FFE;
    req = 4'b0011;
    @(negedge clk);
    chk("clr_pin_low", {31'd0, dac_clr_n}, 32'd0);
    repeat (44) @(negedge clk);
    chk("clr_frame_ack", {28'd0, ack}, 32'd1);
    req = 4'b0010;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lows += int'(!dac_sync_n);
    end
    chk("clr_blocks_grant", lows, 32'd0);
    chk("clr_idle", {31'd0, busy}, 32'd0);
    clear_request = 1'b0;
    @(negedge clk);
    chk("clr_pin_high", {31'd0, dac_clr_n}, 32'd1);
    run_frame(24'h0C0FFE, 4'b0010, "after_clr");
    req = 4'b0000;
    @(negedge clk);
`ifdef FRAME_CNT_EN
    chk("frame_count", {16'd0, frame_count}, 32'd9);
`endif

    cmd[48 +: 24] = 24'h2468AC;
    req = 4'b0100;
    wait_sync();
    repeat (20) @(negedge clk);
    acks_before = ack_pulses;
    rst = 1'b0;
    #1;
    chk("abort_sync_n", {31'd0, dac_sync_n}, 32'd1);
    chk("abort_sclk", {31'd0, dac_sclk}, 32'd1);
    chk("abort_din", {31'd0, dac_din}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk("abort_init_done", {31'd0, init_done}, 32'd0);
    chk("abort_ldac_n", {31'd0, dac_ldac_n}, 32'd1);
    req = 4'b0000;
    clear_request = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    capture(w, ok);
    chk("reinit_word", {8'd0, w}, 32'h200012);
    chk("reinit_shape", {31'd0, ok}, 32'd1);
    repeat (7) @(negedge clk);
    chk("reinit_done", {31'd0, init_done}, 32'd1);
    chk("abort_no_ack", ack_pulses - acks_before, 32'd0);
    clear_request = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
